flash_prog: RTL and testbench

FLASH_PROG -- requirements
Module: flash_prog

---
 rtl/flash_pkg.sv | 48 ++++
 rtl/flash_phase_timer.sv | 28 ++
 rtl/flash_prog.sv | 182 ++++++++++++++++++
 tb/tb_flash_prog.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Flash command codes, status-register bit positions and controller types shared
// by the program/erase controller and the read controller.
package flash_pkg;

    localparam logic [15:0] CMD_ERASE    = 16'h0020;
    localparam logic [15:0] CMD_PROG     = 16'h0040;
    localparam logic [15:0] CMD_CONFIRM  = 16'h00D0;
    localparam logic [15:0] CMD_CLR_SR   = 16'h0050;
    localparam logic [15:0] CMD_READ_ARR = 16'h00FF;
    localparam logic [15:0] CMD_READ_SR  = 16'h0070;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPP_ERR   = 3;
    localparam int SR_LOCK_ERR  = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD_LO,
        ST_CMD_HI,
        ST_DAT_LO,
        ST_DAT_HI,
        ST_POLL_RD,
        ST_POLL_SMP,
        ST_CLR_LO,
        ST_CLR_HI,
        ST_ARR_LO,
        ST_ARR_HI
    } prog_state_t;

    typedef enum logic {
        OP_PROG,
        OP_ERASE
    } op_t;

    typedef struct packed {
        logic        we;
        logic        oe;
        logic        drive;
        logic [15:0] data;
    } bus_ctl_t;

    function automatic logic sr_failed(input logic [7:0] sr);
        return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
    endfunction

endpackage

// File: rtl/flash_phase_timer.sv
// Bus-phase down-counter: reloads on every state change, terminal count when it
// reaches zero, so each state lasts exactly STEP_DIV clocks.
module flash_phase_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tc
);

    localparam int CW = $clog2(STEP_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(STEP_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/flash_prog.sv
// Word-program / block-erase sequencer for a 16-bit parallel NOR flash.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for prog_req / erase_req, bus released
// CMD_LO   | setup command (20 erase / 40 program) on bus, we low
// CMD_HI   | setup command held, we high
// DAT_LO   | confirm (D0) or program word on bus, we low
// DAT_HI   | same data held, we high
// POLL_RD  | bus released, oe low, status settling
// POLL_SMP | oe low, status sampled on last cycle
// CLR_LO   | clear status (50) after failure/timeout, we low
// CLR_HI   | clear status held, we high
// ARR_LO   | back to read array (FF), we low
// ARR_HI   | read array held, we high; done on exit
module flash_prog
    import flash_pkg::*;
#(
    parameter int STEP_DIV = 4,
    parameter int POLL_MAX = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [22:1] addr,
    input  logic [15:0] wdata,
    input  logic        prog_req,
    input  logic        erase_req,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  sr_out,
    inout  tri   [15:0] flash_data,
    output logic [22:0] flash_addr,
    output logic        flash_byte,
    output logic        flash_vpen,
    output logic        flash_ce,
    output logic        flash_rp,
    output logic        flash_oe,
    output logic        flash_we
);

    localparam int PW = $clog2(POLL_MAX + 1);

    prog_state_t state, nxt;
    op_t         op_q, op_n;
    logic [22:1] addr_q, addr_n;
    logic [15:0] wdata_q, wdata_n;
    logic [PW-1:0] poll_cnt;
    logic        accept, smp, sr_ready, timeout, tc, load;
    bus_ctl_t    ctl_n;
    logic        drv_q;
    logic [15:0] dout_q;
    logic        unused_data_hi;

    function automatic bus_ctl_t bus_decode(input prog_state_t s, input op_t op,
                                            input logic [15:0] wd);
        bus_ctl_t c;
        c = '{we: 1'b1, oe: 1'b1, drive: 1'b0, data: 16'h0000};
        case (s)
            ST_CMD_LO, ST_CMD_HI: begin
                c.drive = 1'b1;
                c.data  = (op == OP_ERASE) ? CMD_ERASE : CMD_PROG;
            end
            ST_DAT_LO, ST_DAT_HI: begin
                c.drive = 1'b1;
                c.data  = (op == OP_ERASE) ? CMD_CONFIRM : wd;
            end
            ST_POLL_RD, ST_POLL_SMP: c.oe = 1'b0;
            ST_CLR_LO, ST_CLR_HI: begin
                c.drive = 1'b1;
                c.data  = CMD_CLR_SR;
            end
            ST_ARR_LO, ST_ARR_HI: begin
                c.drive = 1'b1;
                c.data  = CMD_READ_ARR;
            end
            default: ;
        endcase
        c.we = !(s == ST_CMD_LO || s == ST_DAT_LO || s == ST_CLR_LO || s == ST_ARR_LO);
        return c;
    endfunction

    flash_phase_timer #(.STEP_DIV(STEP_DIV)) u_phase (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .tc   (tc)
    );

    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        smp      = 1'b0;
        sr_ready = flash_data[SR_READY];
        timeout  = (poll_cnt == PW'(POLL_MAX - 1));
        case (state)
            ST_IDLE:     if (erase_req || prog_req) begin
                             accept = 1'b1;
                             nxt    = ST_CMD_LO;
                         end
            ST_CMD_LO:   if (tc) nxt = ST_CMD_HI;
            ST_CMD_HI:   if (tc) nxt = ST_DAT_LO;
            ST_DAT_LO:   if (tc) nxt = ST_DAT_HI;
            ST_DAT_HI:   if (tc) nxt = ST_POLL_RD;
            ST_POLL_RD:  if (tc) nxt = ST_POLL_SMP;
            ST_POLL_SMP: if (tc) begin
                             smp = 1'b1;
                             if (sr_ready)
                                 nxt = sr_failed(flash_data[7:0]) ? ST_CLR_LO : ST_ARR_LO;
                             else if (timeout)
                                 nxt = ST_CLR_LO;
                             else
                                 nxt = ST_POLL_RD;
                         end
            ST_CLR_LO:   if (tc) nxt = ST_CLR_HI;
            ST_CLR_HI:   if (tc) nxt = ST_ARR_LO;
            ST_ARR_LO:   if (tc) nxt = ST_ARR_HI;
            ST_ARR_HI:   if (tc) nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
        endcase
        // Bus outputs are registered from the next state so they line up with it.
        op_n    = accept ? (erase_req ? OP_ERASE : OP_PROG) : op_q;
        addr_n  = accept ? addr : addr_q;
        wdata_n = accept ? wdata : wdata_q;
        ctl_n   = bus_decode(nxt, op_n, wdata_n);
    end

    assign load = (nxt != state);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_PROG;
            addr_q     <= '0;
            wdata_q    <= '0;
            poll_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            sr_out     <= 8'h00;
            flash_we   <= 1'b1;
            flash_oe   <= 1'b1;
            drv_q      <= 1'b0;
            dout_q     <= 16'h0000;
            flash_addr <= '0;
        end else begin
            state <= nxt;
            busy  <= (nxt != ST_IDLE);
            done  <= (state == ST_ARR_HI) && (nxt == ST_IDLE);
            if (accept) begin
                op_q     <= op_n;
                addr_q   <= addr;
                wdata_q  <= wdata;
                poll_cnt <= '0;
                error    <= 1'b0;
            end
            if (smp) begin
                sr_out <= flash_data[7:0];
                if (sr_ready)
                    error <= sr_failed(flash_data[7:0]);
                else if (timeout)
                    error <= 1'b1;
                else
                    poll_cnt <= poll_cnt + PW'(1);
            end
            flash_we   <= ctl_n.we;
            flash_oe   <= ctl_n.oe;
            drv_q      <= ctl_n.drive;
            dout_q     <= ctl_n.data;
            flash_addr <= (nxt == ST_IDLE) ? 23'h0 : {addr_n, 1'b0};
        end
    end

    assign flash_data     = drv_q ? dout_q : 16'hzzzz;
    assign unused_data_hi = ^flash_data[15:8];

    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_ce   = 1'b0;
    assign flash_rp   = 1'b1;

endmodule

// File: tb/tb_flash_prog.sv
// Directed bench for flash_prog: flash status model, bus-write logger, per-op checks.
module tb_flash_prog;

    localparam int STEP_DIV = 4;
    localparam int POLL_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [22:1] addr = '0;
    logic [15:0] wdata = '0;
    logic        prog_req = 1'b0;
    logic        erase_req = 1'b0;
    logic        busy, done, error;
    logic [7:0]  sr_out;
    tri   [15:0] flash_data;
    logic [22:0] flash_addr;
    logic        flash_byte, flash_vpen, flash_ce, flash_rp, flash_oe, flash_we;

    int checks = 0;
    int failures = 0;

    flash_prog #(.STEP_DIV(STEP_DIV), .POLL_MAX(POLL_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .prog_req   (prog_req),
        .erase_req  (erase_req),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .sr_out     (sr_out),
        .flash_data (flash_data),
        .flash_addr (flash_addr),
        .flash_byte (flash_byte),
        .flash_vpen (flash_vpen),
        .flash_ce   (flash_ce),
        .flash_rp   (flash_rp),
        .flash_oe   (flash_oe),
        .flash_we   (flash_we)
    );

    always #5 clk = ~clk;

    // Flash model: status reads busy (00) for model_busy polls, then model_ready_sr.
    int         model_busy = 0;
    logic [7:0] model_ready_sr = 8'h80;
    int         oe_cnt = 0;
    logic [7:0] model_sr;

    always @(posedge clk) oe_cnt <= (flash_oe == 1'b0) ? oe_cnt + 1 : 0;
    assign model_sr   = (oe_cnt >= model_busy * 2 * STEP_DIV) ? model_ready_sr : 8'h00;
    assign flash_data = (flash_oe == 1'b0) ? {8'h00, model_sr} : 16'hzzzz;

    // Logger: each falling edge of we is one bus write.
    logic [15:0] wr_data[$];
    logic [22:0] wr_addr[$];
    logic        we_prev = 1'b1;
    int          oe_cycles = 0;
    int          busy_cycles = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (flash_we == 1'b0 && we_prev == 1'b1) begin
            wr_data.push_back(flash_data);
            wr_addr.push_back(flash_addr);
        end
        we_prev = flash_we;
        if (flash_oe == 1'b0) oe_cycles++;
        if (busy) busy_cycles++;
        if (done) done_cnt++;
    end

    int w0, oe0, b0, d0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        w0  = wr_data.size();
        oe0 = oe_cycles;
        b0  = busy_cycles;
        d0  = done_cnt;
    endtask

    task automatic run_op(input bit er, input bit pr, input logic [22:1] a,
                          input logic [15:0] d, input int bpolls,
                          input logic [7:0] rsr, input bit poke);
        bit seen;
        seen = 1'b0;
        model_busy = bpolls;
        model_ready_sr = rsr;
        snap();
        addr = a;
        wdata = d;
        erase_req = er;
        prog_req = pr;
        step();
        erase_req = 1'b0;
        prog_req = 1'b0;
        addr = 22'h3FFFFF;
        wdata = 16'h1234;
        check_val("busy_after_accept", busy, 1'b1);
        check_val("error_cleared", error, 1'b0);
        for (int i = 0; i < 400; i++) begin
            prog_req = (poke && i == 5);
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        prog_req = 1'b0;
        check_val("done_seen", seen, 1'b1);
        check_val("busy_low_at_done", busy, 1'b0);
        step();
        check_val("done_one_cycle", done, 1'b0);
    endtask

    task automatic check_writes(input int n, input logic [22:0] a0, input logic [15:0] e0,
                                input logic [15:0] e1, input logic [15:0] e2,
                                input logic [15:0] e3);
        logic [15:0] exp[4];
        exp = '{e0, e1, e2, e3};
        check_val("wr_count", wr_data.size() - w0, n);
        if (wr_data.size() > w0) check_val("wr_addr", wr_addr[w0], a0);
        for (int i = 0; i < n; i++)
            if (w0 + i < wr_data.size()) check_val($sformatf("wr_%0d", i), wr_data[w0 + i], exp[i]);
    endtask

    initial begin
        bit seen;
        repeat (3) step();
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_error", error, 1'b0);
        check_val("rst_sr", sr_out, 8'h00);
        check_val("rst_we", flash_we, 1'b1);
        check_val("rst_oe", flash_oe, 1'b1);
        check_val("rst_addr", flash_addr, 23'h0);
        check_val("ties", {flash_byte, flash_vpen, flash_ce, flash_rp}, 4'b1101);
        rst = 1'b1;
        repeat (2) step();

        // Program, ready on first poll.
        run_op(1'b0, 1'b1, 22'h000010, 16'hBEEF, 0, 8'h80, 1'b0);
        check_writes(3, 23'h000020, 16'h0040, 16'hBEEF, 16'h00FF, 16'h0000);
        check_val("p_error", error, 1'b0);
        check_val("p_sr", sr_out, 8'h80);
        check_val("p_busy_cycles", busy_cycles - b0, 32);
        check_val("p_poll_cycles", oe_cycles - oe0, 8);

        // Erase and program together; program poked while busy; 3 busy polls.
        run_op(1'b1, 1'b1, 22'h010000, 16'hCAFE, 3, 8'h80, 1'b1);
        check_writes(3, 23'h020000, 16'h0020, 16'h00D0, 16'h00FF, 16'h0000);
        check_val("e_error", error, 1'b0);
        check_val("e_sr", sr_out, 8'h80);
        check_val("e_poll_cycles", oe_cycles - oe0, 32);
        check_val("e_busy_cycles", busy_cycles - b0, 56);
        repeat (20) step();
        check_val("e_no_restart", busy_cycles - b0, 56);

        // Program failure: SR=90 after one busy poll.
        run_op(1'b0, 1'b1, 22'h000123, 16'h5A5A, 1, 8'h90, 1'b0);
        check_writes(4, 23'h000246, 16'h0040, 16'h5A5A, 16'h0050, 16'h00FF);
        check_val("f_error", error, 1'b1);
        check_val("f_sr", sr_out, 8'h90);
        check_val("f_busy_cycles", busy_cycles - b0, 48);
        repeat (5) step();
        check_val("f_error_hold", error, 1'b1);

        // Poll timeout: status never ready.
        run_op(1'b0, 1'b1, 22'h2AAAAA, 16'h0000, 1000, 8'h80, 1'b0);
        check_writes(4, 23'h555554, 16'h0040, 16'h0000, 16'h0050, 16'h00FF);
        check_val("t_error", error, 1'b1);
        check_val("t_sr", sr_out, 8'h00);
        check_val("t_poll_cycles", oe_cycles - oe0, 64);
        check_val("t_busy_cycles", busy_cycles - b0, 96);

        // Reset during DAT_LO.
        model_busy = 0;
        model_ready_sr = 8'h80;
        snap();
        addr = 22'h000040;
        wdata = 16'h7777;
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wr_data.size() >= w0 + 2) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check_val("r_reached_dat_lo", seen, 1'b1);
        check_val("r_dat_lo_we", flash_we, 1'b0);
        rst = 1'b0;
        step();
        check_val("r_we", flash_we, 1'b1);
        check_val("r_oe", flash_oe, 1'b1);
        check_val("r_busy", busy, 1'b0);
        check_val("r_error", error, 1'b0);
        check_val("r_addr", flash_addr, 23'h0);
        check_val("r_sr", sr_out, 8'h00);
        rst = 1'b1;
        repeat (40) step();
        check_val("r_no_done", done_cnt - d0, 0);
        check_val("r_no_writes", wr_data.size() - w0, 2);

        // Clean program after reset.
        run_op(1'b0, 1'b1, 22'h000001, 16'h0123, 0, 8'h80, 1'b0);
        check_writes(3, 23'h000002, 16'h0040, 16'h0123, 16'h00FF, 16'h0000);
        check_val("a_error", error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
